// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control for the RV32I integer datapath.
// Decodes R-type and I-type ALU instructions and halts on illegal words or fetch timeout.
module cpu_sequencer #(
    parameter int RETIRE_W      = 16,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         ir,
    output logic                ir_write,
    output logic [2:0]          alu_op,
    output logic                use_imm,
    output logic                reg_write,
    output logic                pc_write,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic                timeout,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_e;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    state_e                state_q, state_d;
    logic [31:0]           ir_q, ir_d;
    alu_op_e               alu_op_q, alu_op_d;
    logic                  use_imm_q, use_imm_d;
    logic                  illegal_q, illegal_d;
    logic                  timeout_q, timeout_d;
    logic                  stop_q, stop_d;
    logic [7:0]            wait_q, wait_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;

    logic                  dec_legal;
    alu_op_e               dec_op;
    logic                  dec_imm;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [7:0]            wait_inc;

    assign funct3   = ir_q[14:12];
    assign funct7   = ir_q[31:25];
    assign wait_inc = wait_q + 8'd1;

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_imm   = 1'b0;
        case (ir_q[6:0])
            OPC_R: begin
                // Only SUB may carry the alternate funct7; SRA and friends are rejected.
                if (funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b000)) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_op = funct7[5] ? ALU_SUB : ALU_ADD;
                        3'b001:  dec_op = ALU_SLL;
                        3'b010:  dec_op = ALU_SLT;
                        3'b100:  dec_op = ALU_XOR;
                        3'b101:  dec_op = ALU_SRL;
                        3'b110:  dec_op = ALU_OR;
                        3'b111:  dec_op = ALU_AND;
                        default: dec_legal = 1'b0;
                    endcase
                end
            end
            OPC_I: begin
                dec_imm   = 1'b1;
                dec_legal = 1'b1;
                case (funct3)
                    3'b000:  dec_op = ALU_ADD;
                    3'b001: begin
                        dec_op    = ALU_SLL;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    3'b010:  dec_op = ALU_SLT;
                    3'b100:  dec_op = ALU_XOR;
                    3'b101: begin
                        dec_op    = ALU_SRL;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    3'b110:  dec_op = ALU_OR;
                    3'b111:  dec_op = ALU_AND;
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_op_d  = alu_op_q;
        use_imm_d = use_imm_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retired_d = retired_q;
        stop_d    = stop_q | stop;
        wait_d    = 8'd0;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        case (state_q)
            S_IDLE: begin
                stop_d = start ? (stop_q | stop) : 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                // An ack on the final permitted cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_d     = imem_rdata;
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_inc == 8'(FETCH_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    alu_op_d  = dec_op;
                    use_imm_d = dec_imm;
                    state_d   = S_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                reg_write = (ir_q[11:7] != 5'd0);
                pc_write  = 1'b1;
                retired_d = retired_q + RETIRE_W'(1);
                stop_d    = 1'b0;
                state_d   = (stop_q | stop) ? S_IDLE : S_FETCH;
            end
            default: begin
                stop_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ir_q      <= 32'd0;
            alu_op_q  <= ALU_ADD;
            use_imm_q <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            stop_q    <= 1'b0;
            wait_q    <= 8'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            alu_op_q  <= alu_op_d;
            use_imm_q <= use_imm_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            stop_q    <= stop_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    assign ir      = ir_q;
    assign alu_op  = alu_op_q;
    assign use_imm = use_imm_q;
    assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign retired = retired_q;

endmodule
